// File: rtl/rv0_pkg.sv
// Shared rv0 core definitions: register-file address width and write-back source indices.
package rv0_pkg;

  localparam int RF_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_EI = 2'd0,
    WB_MA = 2'd1,
    WB_EM = 2'd2
  } wb_src_e;

endpackage

// File: rtl/rv0_rr_arb.sv
// Generic N-way round-robin arbiter: one-hot grant plus index, pointer advances past each winner.
module rv0_rr_arb
  import rv0_pkg::*;
#(
  parameter int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_nxt;
  logic [IW:0]   idx_w;
  logic          found;

  // Walk ptr_q, ptr_q+1, ... with wrap at N; first requester seen wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx_w   = '0;
    for (int i = 0; i < N; i++) begin
      idx_w = {1'b0, ptr_q} + (IW+1)'(i);
      if (idx_w >= (IW+1)'(N)) idx_w = idx_w - (IW+1)'(N);
      if (!found && req[idx_w[IW-1:0]]) begin
        found                 = 1'b1;
        gnt[idx_w[IW-1:0]]    = 1'b1;
        gnt_idx               = idx_w[IW-1:0];
      end
    end
  end

  assign ptr_nxt = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + IW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= ptr_nxt;
    end
  end

endmodule

// File: rtl/rv0_wb_arb.sv
// Integer write-back arbiter: round-robin over result units into one registered RF write port.
// Optional conflict counter output enabled by defining RV0_WB_ARB_PERF_EN.
module rv0_wb_arb
  import rv0_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREQ = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NREQ-1:0]           req_valid_i,
  input  logic [NREQ*RF_ADDR_W-1:0] req_rd_i,
  input  logic [NREQ*XLEN-1:0]      req_data_i,
  output logic [NREQ-1:0]           req_ack_o,
  output logic [RF_ADDR_W-1:0]      rfi_waddr_o,
  output logic [XLEN-1:0]           rfi_wdata_o,
  output logic                      rfi_we_o
`ifdef RV0_WB_ARB_PERF_EN
  ,
  output logic [31:0]               wb_conflict_cnt_o
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      gnt;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_any;
  logic [RF_ADDR_W-1:0] rd_p0;
  logic [XLEN-1:0]      data_p0;
  logic                 vld_p1;
  logic [RF_ADDR_W-1:0] waddr_p1;
  logic [XLEN-1:0]      wdata_p1;

  rv0_rr_arb #(.N(NREQ)) u_rr_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req     (req_valid_i),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Stage p0: grant and operand select, all combinational in the grant cycle.
  assign req_ack_o = rst_ni ? gnt : '0;
  assign gnt_any   = |req_ack_o;
  assign rd_p0     = req_rd_i[RF_ADDR_W*int'(gnt_idx) +: RF_ADDR_W];
  assign data_p0   = req_data_i[XLEN*int'(gnt_idx) +: XLEN];

  // Stage p1: registered write port; x0 results update addr/data but never pulse we.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= gnt_any && (rd_p0 != '0);
      if (gnt_any) begin
        waddr_p1 <= rd_p0;
        wdata_p1 <= data_p0;
      end
    end
  end

  assign rfi_we_o    = vld_p1;
  assign rfi_waddr_o = waddr_p1;
  assign rfi_wdata_o = wdata_p1;

`ifdef RV0_WB_ARB_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] conflict_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_q <= '0;
    end else if ($countones(req_valid_i) > 1) begin
      conflict_cnt_q <= sat_inc(conflict_cnt_q);
    end
  end

  assign wb_conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_rv0_wb_arb.sv
// Self-checking bench for rv0_wb_arb (NREQ=3) against a rotating-priority reference model.
module tb_rv0_wb_arb;
  import rv0_pkg::*;

  localparam int XLEN = 32;
  localparam int NREQ = 3;

  logic                 clk = 1'b0;
  logic                 rst_ni;
  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ*5-1:0]    req_rd_i;
  logic [NREQ*XLEN-1:0] req_data_i;
  logic [NREQ-1:0]      req_ack_o;
  logic [4:0]           rfi_waddr_o;
  logic [XLEN-1:0]      rfi_wdata_o;
  logic                 rfi_we_o;
`ifdef RV0_WB_ARB_PERF_EN
  logic [31:0]          wb_conflict_cnt_o;
`endif

  always #5 clk = ~clk;

  rv0_wb_arb #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_rd_i    (req_rd_i),
    .req_data_i  (req_data_i),
    .req_ack_o   (req_ack_o),
    .rfi_waddr_o (rfi_waddr_o),
    .rfi_wdata_o (rfi_wdata_o),
    .rfi_we_o    (rfi_we_o)
`ifdef RV0_WB_ARB_PERF_EN
    ,
    .wb_conflict_cnt_o (wb_conflict_cnt_o)
`endif
  );

  logic [NREQ-1:0] valid;
  logic [4:0]      rd  [NREQ];
  logic [31:0]     dat [NREQ];

  always_comb begin
    req_valid_i = valid;
    req_rd_i    = '0;
    req_data_i  = '0;
    for (int n = 0; n < NREQ; n++) begin
      req_rd_i[5*n +: 5]        = rd[n];
      req_data_i[XLEN*n +: XLEN] = dat[n];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int              m_ptr;
  logic            m_we;
  logic [4:0]      m_addr;
  logic [31:0]     m_data;
  logic [31:0]     m_cnt;
  logic [NREQ-1:0] got_ack;
  int              last_g;

  task automatic model_reset();
    m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_cnt = '0;
  endtask

  // Called at a negedge with inputs set; returns at the following negedge.
  task automatic step();
    int g;
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (g < 0 && valid[idx]) g = idx;
    end
    got_ack = req_ack_o;
    chk("ack", {61'd0, got_ack}, (g >= 0) ? 64'(1) << g : 64'd0);
    last_g = g;
    if (g >= 0) begin
      m_ptr  = (g + 1) % NREQ;
      m_addr = rd[g];
      m_data = dat[g];
      m_we   = (rd[g] != 5'd0);
    end else begin
      m_we = 1'b0;
    end
    if ($countones(valid) >= 2 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    @(posedge clk);
    @(negedge clk);
    chk("we", {63'd0, rfi_we_o}, {63'd0, m_we});
    chk("waddr", {59'd0, rfi_waddr_o}, {59'd0, m_addr});
    chk("wdata", {32'd0, rfi_wdata_o}, {32'd0, m_data});
`ifdef RV0_WB_ARB_PERF_EN
    chk("cnt", {32'd0, wb_conflict_cnt_o}, {32'd0, m_cnt});
`endif
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    valid  = '1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_we", {63'd0, rfi_we_o}, 64'd0);
    chk("rst_waddr", {59'd0, rfi_waddr_o}, 64'd0);
    chk("rst_wdata", {32'd0, rfi_wdata_o}, 64'd0);
    chk("rst_ack", {61'd0, req_ack_o}, 64'd0);
    valid  = '0;
    rst_ni = 1'b1;
  endtask

  int seq [6] = '{0, 1, 2, 0, 1, 2};
  logic            pending [NREQ];
  int              wait_c  [NREQ];

  initial begin
    rst_ni = 1'b0;
    valid  = '0;
    for (int n = 0; n < NREQ; n++) begin rd[n] = '0; dat[n] = '0; end
    model_reset();
    @(negedge clk);
    apply_reset();

    // Contention: EI and MA valid from reset, back-to-back writes
    valid = 3'b011;
    rd[int'(WB_EI)] = 5'd1; dat[int'(WB_EI)] = 32'd1;
    rd[int'(WB_MA)] = 5'd2; dat[int'(WB_MA)] = 32'd2;
    step();
    chk("cont_ack0", {61'd0, got_ack}, 64'b001);
    chk("cont_w0", {58'd0, rfi_we_o, rfi_waddr_o}, {58'd0, 1'b1, 5'd1});
    valid = 3'b010;
    step();
    chk("cont_ack1", {61'd0, got_ack}, 64'b010);
    chk("cont_w1", {58'd0, rfi_we_o, rfi_waddr_o}, {58'd0, 1'b1, 5'd2});
    valid = '0;
    step();

    // Single request
    valid = 3'b001; rd[0] = 5'd5; dat[0] = 32'hDEAD_BEEF;
    step();
    chk("single_we", {63'd0, rfi_we_o}, 64'd1);
    chk("single_data", {32'd0, rfi_wdata_o}, 64'hDEAD_BEEF);
    valid = '0;
    step();
    chk("single_we_off", {63'd0, rfi_we_o}, 64'd0);

    // x0 destination
    valid = 3'b010; rd[1] = 5'd0; dat[1] = 32'h1234;
    step();
    chk("x0_ack", {61'd0, got_ack}, 64'b010);
    chk("x0_we", {63'd0, rfi_we_o}, 64'd0);
    chk("x0_data", {32'd0, rfi_wdata_o}, 64'h1234);
    valid = '0;

    // Fairness from a fresh pointer
    apply_reset();
    for (int n = 0; n < NREQ; n++) begin rd[n] = 5'(n + 10); dat[n] = 32'(n + 100); end
    valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("fair", {61'd0, got_ack}, 64'(1) << seq[i]);
    end
    valid = '0;

`ifdef RV0_WB_ARB_PERF_EN
    apply_reset();
    valid = 3'b011; rd[0] = 5'd3; rd[1] = 5'd4;
    repeat (4) step();
    valid = 3'b001;
    repeat (3) step();
    chk("perf_cnt", {32'd0, wb_conflict_cnt_o}, 64'd4);
    valid = '0;
`endif

    // Reset while a write is in flight
    valid = 3'b001; rd[0] = 5'd5; dat[0] = 32'hCAFE_0001;
    step();
    chk("mid_we_pre", {63'd0, rfi_we_o}, 64'd1);
    #2;
    rst_ni = 1'b0;
    valid  = 3'b110;
    #1;
    chk("mid_we", {63'd0, rfi_we_o}, 64'd0);
    chk("mid_waddr", {59'd0, rfi_waddr_o}, 64'd0);
    chk("mid_ack", {61'd0, req_ack_o}, 64'd0);
    model_reset();
    @(negedge clk);
    rd[1] = 5'd7; dat[1] = 32'h77; rd[2] = 5'd8; dat[2] = 32'h88;
    rst_ni = 1'b1;
    step();
    chk("mid_first", {61'd0, got_ack}, 64'b010);
    valid = '0;
    step();

    // Randomized traffic with stable-until-ack requesters
    for (int n = 0; n < NREQ; n++) begin pending[n] = 1'b0; wait_c[n] = 0; end
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < NREQ; n++) begin
        if (!pending[n] && ($urandom_range(0, 2) != 0)) begin
          pending[n] = 1'b1;
          rd[n]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          dat[n] = $urandom;
          wait_c[n] = 0;
        end
        valid[n] = pending[n];
      end
      step();
      for (int n = 0; n < NREQ; n++) begin
        if (pending[n]) begin
          if (got_ack[n]) begin
            chk("starve", 64'(wait_c[n] < NREQ), 64'd1);
            pending[n] = 1'b0;
          end else begin
            wait_c[n]++;
          end
        end
      end
    end
    valid = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rv0_wb_arb.md
Name: rv0_wb_arb

Overview:
Integer write-back arbiter for the rv0 core. It shares the single integer register-file write port (rfi_waddr/rfi_wdata/rfi_we at the decode unit) between the execution units, such as EI and MA, and later EM. It uses round-robin arbitration with a valid/ack handshake per requester. The write port is driven from a registered stage, so every accepted result produces exactly one write pulse. The decode unit's reservation counters decrement correctly from that pulse.

Parameters:
XLEN, 32, integer datapath width
NREQ, 2, number of result requesters (2..4); index 0 = EI, 1 = MA, 2 = EM

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  NREQ  requester n has a result pending
req_rd_i  in  NREQ*5  destination register, requester n at bits [5n+4:5n]
req_data_i  in  NREQ*XLEN  result data, requester n at bits [XLEN*n+XLEN-1:XLEN*n]
req_ack_o  out  NREQ  one-hot grant; result accepted this cycle
rfi_waddr_o  out  5  write address to integer register file
rfi_wdata_o  out  XLEN  write data
rfi_we_o  out  1  write enable, one cycle per accepted result with rd!=0

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - rfi_we_o=0, rfi_waddr_o=0, rfi_wdata_o=0.
  - Round-robin pointer ptr_q=0.
  - req_ack_o=0 while in reset.
- Handshake:
  - A requester holds valid, rd and data stable until it sees ack.
  - Transfer occurs on any cycle where valid and ack are both 1.
  - req_ack_o is combinational from req_valid_i and ptr_q.
  - req_ack_o is at most one-hot and never asserted for an invalid requester.
- Arbitration:
  - Search indices ptr_q, ptr_q+1, ... mod NREQ; the first valid index g is granted.
  - On a grant, ptr_q <= (g+1) mod NREQ.
  - With no valid requester, ptr_q holds and req_ack_o=0.
- Throughput and latency:
  - One grant per cycle; no bubbles under continuous requests.
  - Write latency is 1 cycle: the grant in cycle t gives rfi_we_o=1 in cycle t+1, with the latched rd and data.
  - rfi_we_o deasserts in t+2 unless another grant occurs in t+1.
- x0 handling:
  - A request with rd=0 is acked normally.
  - rfi_we_o stays 0 for it; rfi_waddr_o and rfi_wdata_o still update.
- Ordering and fairness:
  - Results from the same requester are written in acceptance order.
  - No ordering is guaranteed across requesters; WAW ordering across units is the decode unit's responsibility.
  - A requester held valid is granted within NREQ cycles (starvation-free).
- Single requester: it is granted every cycle it is valid.
- No flush input: accepted results always retire, keeping reservation counts consistent.

Optional Feature:
Macro: RV0_WB_ARB_PERF_EN.
- Defined:
  - Adds output port wb_conflict_cnt_o (32 bits), reset to 0.
  - Increments by 1 each cycle where at least two req_valid_i bits are set.
  - Saturates at 32'hFFFF_FFFF.
- Undefined:
  - Port and counter are absent.
  - Arbitration behaviour is identical in both builds.

Decomposition:
- rv0_pkg:
  - localparam RF_ADDR_W=5.
  - enum wb_src_e {WB_EI=0, WB_MA=1, WB_EM=2} for requester index assignment.
- Sub-module rv0_rr_arb #(N):
  - Inputs: req (N), clk_i, rst_ni.
  - Outputs: gnt (one-hot), gnt_idx.
  - Owns ptr_q and the wrap-around search.
  - Reusable for future FP write-back.
- The top level does data/rd muxing from gnt_idx and holds the output register stage.

Test Plan:
- Reset mid-operation: assert rst_ni=0 while rfi_we_o=1 -> rfi_we_o=0 immediately; ptr_q=0; after release, first grant goes to the lowest valid index.
- Single request: EI valid, rd=5, data=32'hDEAD_BEEF for 1 cycle -> ack[0] same cycle; next cycle rfi_we_o=1, waddr=5, wdata=32'hDEAD_BEEF; cycle after rfi_we_o=0.
- Contention: EI (rd=1, data=1) and MA (rd=2, data=2) both held valid from reset -> grants EI, then MA; writes rd1 then rd2 on consecutive cycles; no idle cycle.
- Fairness: NREQ=3, all valid for 6 cycles -> grant sequence 0,1,2,0,1,2; no requester waits more than 3 cycles.
- x0 write: MA valid, rd=0, data=32'h1234 -> ack[1]=1; rfi_we_o stays 0 next cycle.
- Perf counter (RV0_WB_ARB_PERF_EN): 4 cycles with 2 valid plus 3 cycles with 1 valid -> wb_conflict_cnt_o=4.
